// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned RA_W_DEF   = 5;
    localparam int unsigned CNT_W_DEF  = 32;

    // HZ_RUN / HZ_REDIRECT / HZ_MEM_WAIT keep the legacy 2-bit encodings.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_REDIRECT = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    // Same-cycle stall/flush controls sent to the pipeline registers.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_exe_flush;
        logic pipe_hold;
    } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating event counter with synchronous active-high clear.
module hazard_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count one event per cycle and stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, registered branch/jump
// redirect, and a global freeze while data memory is busy.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RA_W   = RA_W_DEF
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RA_W-1:0]   id_rs1_i,
    input  logic [RA_W-1:0]   id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              ex_MemRead_i,
    input  logic [RA_W-1:0]   ex_reg_dest_i,
    input  logic              ex_branch_taken_i,
    input  logic [ADDR_W-1:0] ex_branch_addr_i,
    input  logic              ex_jump_enable_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              mem_busy_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_exe_flush_o,
    output logic              pipe_hold_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_lu_cnt_o,
    output logic [CNT_W-1:0]  perf_redirect_cnt_o,
    output logic [CNT_W-1:0]  perf_memwait_cnt_o
`endif
);

    hz_state_e         state;
    hz_state_e         state_nxt;
    hz_ctrl_t          ctrl;
    logic              lu;
    logic              ct;
    logic [ADDR_W-1:0] ct_target;
    logic              capture;
    logic              release_redir;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;

    // Hazard detection; x0 never creates a dependency, jump beats branch.
    assign lu = ex_MemRead_i && (ex_reg_dest_i != '0) &&
                ((id_use_rs1_i && (id_rs1_i == ex_reg_dest_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_reg_dest_i)));
    assign ct        = ex_branch_taken_i | ex_jump_enable_i;
    assign ct_target = ex_jump_enable_i ? ex_jump_addr_i : ex_branch_addr_i;

    // Next state and same-cycle controls; priority mem_busy > ct > lu.
    always_comb begin
        state_nxt     = state;
        ctrl          = '0;
        capture       = 1'b0;
        release_redir = 1'b0;
        case (state)
            HZ_REDIRECT: begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_exe_flush = 1'b1;
                if (mem_busy_i) begin
                    ctrl.pipe_hold = 1'b1;
                    ctrl.pc_stall  = 1'b1;
                end else begin
                    release_redir = 1'b1;
                    state_nxt     = HZ_RUN;
                end
            end
            HZ_RUN, HZ_MEM_WAIT: begin
                if (mem_busy_i) begin
                    ctrl.pipe_hold   = 1'b1;
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_stall = 1'b1;
                    state_nxt        = HZ_MEM_WAIT;
                end else if (ct) begin
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_exe_flush = 1'b1;
                    capture           = 1'b1;
                    state_nxt         = HZ_REDIRECT;
                end else begin
                    state_nxt = HZ_RUN;
                    if (lu) begin
                        ctrl.pc_stall     = 1'b1;
                        ctrl.if_id_stall  = 1'b1;
                        ctrl.id_exe_flush = 1'b1;
                    end
                end
            end
            default: state_nxt = HZ_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= HZ_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect target register; held across a memory stall, dropped on exit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else if (capture) begin
            redirect_valid <= 1'b1;
            redirect_addr  <= ct_target;
        end else if (release_redir) begin
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end
    end

    assign pc_stall_o       = ctrl.pc_stall;
    assign if_id_stall_o    = ctrl.if_id_stall;
    assign if_id_flush_o    = ctrl.if_id_flush;
    assign id_exe_flush_o   = ctrl.id_exe_flush;
    assign pipe_hold_o      = ctrl.pipe_hold;
    assign redirect_valid_o = redirect_valid;
    assign redirect_addr_o  = redirect_addr;

`ifdef HAZARD_PERF_CNT_EN
    logic lu_bubble;
    logic in_mem_wait;

    // Event strobes: bubble inserted, redirect entered, cycle spent waiting.
    assign lu_bubble   = (state != HZ_REDIRECT) && !mem_busy_i && !ct && lu;
    assign in_mem_wait = (state == HZ_MEM_WAIT);

    hazard_perf_cnt #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (lu_bubble),
        .count (perf_lu_cnt_o)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (capture),
        .count (perf_redirect_cnt_o)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_memwait_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (in_mem_wait),
        .count (perf_memwait_cnt_o)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level model checked every cycle plus
// directed vectors with hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_dest;
    logic          use1, use2, mem_read, br_taken, jmp_en, mem_busy;
    logic [AW-1:0] br_addr, jmp_addr;
    logic          pc_stall, if_id_stall, if_id_flush, id_exe_flush, pipe_hold, redir_valid;
    logic [AW-1:0] redir_addr;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   perf_lu, perf_redir, perf_mw;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Model state: is a redirect outstanding, and to where.
    bit            m_redir = 1'b0;
    logic [AW-1:0] m_addr  = '0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_use_rs1_i      (use1),
        .id_use_rs2_i      (use2),
        .ex_MemRead_i      (mem_read),
        .ex_reg_dest_i     (ex_dest),
        .ex_branch_taken_i (br_taken),
        .ex_branch_addr_i  (br_addr),
        .ex_jump_enable_i  (jmp_en),
        .ex_jump_addr_i    (jmp_addr),
        .mem_busy_i        (mem_busy),
        .pc_stall_o        (pc_stall),
        .if_id_stall_o     (if_id_stall),
        .if_id_flush_o     (if_id_flush),
        .id_exe_flush_o    (id_exe_flush),
        .pipe_hold_o       (pipe_hold),
        .redirect_valid_o  (redir_valid),
        .redirect_addr_o   (redir_addr)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_cnt_o       (perf_lu),
        .perf_redirect_cnt_o (perf_redir),
        .perf_memwait_cnt_o  (perf_mw)
`endif
    );

    // Outputs packed as {pc_stall, if_id_stall, if_id_flush, id_exe_flush, pipe_hold, redirect_valid}.
    function automatic logic [5:0] dut_vec();
        return {pc_stall, if_id_stall, if_id_flush, id_exe_flush, pipe_hold, redir_valid};
    endfunction

    function automatic bit m_lu();
        return mem_read && (ex_dest != 0) &&
               ((use1 && id_rs1 == ex_dest) || (use2 && id_rs2 == ex_dest));
    endfunction

    // Expected outputs from the hazard rules for the current cycle.
    function automatic logic [5:0] m_vec();
        if (m_redir)                return {mem_busy, 1'b0, 1'b1, 1'b1, mem_busy, 1'b1};
        else if (mem_busy)          return 6'b110010;
        else if (br_taken || jmp_en) return 6'b001100;
        else if (m_lu())            return 6'b110100;
        else                        return 6'b000000;
    endfunction

    // Model state advance at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            m_redir <= 1'b0;
            m_addr  <= '0;
        end else if (m_redir) begin
            if (!mem_busy) begin
                m_redir <= 1'b0;
                m_addr  <= '0;
            end
        end else if (!mem_busy && (br_taken || jmp_en)) begin
            m_redir <= 1'b1;
            m_addr  <= jmp_en ? jmp_addr : br_addr;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (dut_vec() !== m_vec() || redir_addr !== m_addr) begin
                errors++;
                $display("FAIL model t=%0t got ctl=%b addr=%h want ctl=%b addr=%h",
                         $time, dut_vec(), redir_addr, m_vec(), m_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [5:0] exp_ctl, input logic [AW-1:0] exp_addr);
        checks++;
        if (dut_vec() !== exp_ctl || redir_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s got ctl=%b addr=%h want ctl=%b addr=%h",
                     name, dut_vec(), redir_addr, exp_ctl, exp_addr);
        end
    endtask

    // Advance to just after the next rising edge and clear all inputs.
    task automatic nxt();
        @(posedge clk);
        #1;
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_dest = '0;
        use1 = 1'b0; use2 = 1'b0; mem_read = 1'b0; br_taken = 1'b0; jmp_en = 1'b0;
        mem_busy = 1'b0; br_addr = '0; jmp_addr = '0;
    endtask

    task automatic set_lu(input logic [RW-1:0] rd);
        mem_read = 1'b1; ex_dest = rd; id_rs1 = 5'd5; use1 = 1'b1;
    endtask

    initial begin
        nxt();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset", 6'b000000, 32'h0);

        // Load-use, one bubble only; then rd=x0; then rs2 match.
        nxt(); set_lu(5'd5);                                   @(negedge clk); chk("lu_rs1", 6'b110100, 32'h0);
        nxt();                                                 @(negedge clk); chk("lu_gone", 6'b000000, 32'h0);
        nxt(); mem_read = 1'b1; id_rs1 = 5'd0; use1 = 1'b1;    @(negedge clk); chk("lu_x0", 6'b000000, 32'h0);
        nxt(); mem_read = 1'b1; ex_dest = 5'd9; id_rs2 = 5'd9; use2 = 1'b1;
                                                               @(negedge clk); chk("lu_rs2", 6'b110100, 32'h0);
        nxt(); mem_read = 1'b1; ex_dest = 5'd9; id_rs2 = 5'd9; use2 = 1'b0;
                                                               @(negedge clk); chk("lu_nouse", 6'b000000, 32'h0);

        // Taken branch: flush now, redirect next cycle, then quiet.
        nxt(); br_taken = 1'b1; br_addr = 32'h40;              @(negedge clk); chk("br_n", 6'b001100, 32'h0);
        nxt();                                                 @(negedge clk); chk("br_n1", 6'b001101, 32'h40);
        nxt();                                                 @(negedge clk); chk("br_n2", 6'b000000, 32'h0);

        // Jump + branch + load-use together: jump target, no stall.
        nxt(); jmp_en = 1'b1; jmp_addr = 32'h80; br_taken = 1'b1; br_addr = 32'h40; set_lu(5'd5);
                                                               @(negedge clk); chk("sim_n", 6'b001100, 32'h0);
        nxt(); set_lu(5'd5);                                   @(negedge clk); chk("sim_n1", 6'b001101, 32'h80);
        nxt();                                                 @(negedge clk); chk("sim_n2", 6'b000000, 32'h0);

        // Memory busy 3 cycles with a pending load-use, bubble on release.
        for (int i = 0; i < 3; i++) begin
            nxt(); mem_busy = 1'b1; set_lu(5'd5);              @(negedge clk); chk("mw_hold", 6'b110010, 32'h0);
        end
        nxt(); set_lu(5'd5);                                   @(negedge clk); chk("mw_rel_lu", 6'b110100, 32'h0);
        nxt();                                                 @(negedge clk); chk("mw_after", 6'b000000, 32'h0);

        // Memory busy while redirecting: redirect held 3 cycles total.
        nxt(); br_taken = 1'b1; br_addr = 32'h100;             @(negedge clk); chk("rh_n", 6'b001100, 32'h0);
        nxt(); mem_busy = 1'b1;                                @(negedge clk); chk("rh_busy1", 6'b101111, 32'h100);
        nxt(); mem_busy = 1'b1; set_lu(5'd5);                  @(negedge clk); chk("rh_busy2", 6'b101111, 32'h100);
        nxt();                                                 @(negedge clk); chk("rh_last", 6'b001101, 32'h100);
        nxt();                                                 @(negedge clk); chk("rh_clear", 6'b000000, 32'h0);

        // Reset during REDIRECT drops the redirect.
        nxt(); jmp_en = 1'b1; jmp_addr = 32'h44;               @(negedge clk); chk("rst_n", 6'b001100, 32'h0);
        nxt(); rst = 1'b1;                                     @(negedge clk); chk("rst_in_redir", 6'b001101, 32'h44);
        nxt();                                                 @(negedge clk); chk("rst_after", 6'b000000, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (perf_lu !== 0 || perf_redir !== 0 || perf_mw !== 0) begin
            errors++;
            $display("FAIL perf_rst got %0d %0d %0d want 0 0 0", perf_lu, perf_redir, perf_mw);
        end
`endif

        // Mixed vectors checked only by the model.
        for (int i = 0; i < 300; i++) begin
            nxt();
            mem_busy = ($urandom % 5) == 0;
            br_taken = ($urandom % 6) == 0;
            jmp_en   = ($urandom % 8) == 0;
            br_addr  = $urandom;
            jmp_addr = $urandom;
            mem_read = $urandom % 2;
            ex_dest  = RW'($urandom % 4);
            id_rs1   = RW'($urandom % 4);
            id_rs2   = RW'($urandom % 4);
            use1     = $urandom % 2;
            use2     = $urandom % 2;
            rst      = ($urandom % 50) == 0;
            @(negedge clk);
        end

        nxt();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
